// File: rtl/spi_pkg.sv
// spi_pkg
//   Definitions shared by the SPI peripherals (spi_s_main, spi_m_main):
//   - register offsets from the block base address
//   - CTRL and STATUS bit positions
//   - spi_mode_t {cpol, cpha}
//   - the transfer FSM state type
//   - the data width of the serial byte
package spi_pkg;

  localparam int DATA_W = 8;

  // Register offsets from the block base address
  localparam logic [31:0] CTRL_OFF   = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFF = 32'h0000_0004;
  localparam logic [31:0] TXDATA_OFF = 32'h0000_0008;
  localparam logic [31:0] RXDATA_OFF = 32'h0000_000c;

  // CTRL bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_CPHA = 1;
  localparam int CTRL_CPOL = 2;

  // STATUS bit positions
  localparam int ST_RX_VALID = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_BUSY     = 2;
  localparam int ST_TX_UNF   = 3;
  localparam int ST_RX_OVF   = 4;

  // Packed so {cpol, cpha} lines up with CTRL[2:1]
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } spi_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo
//   Synchronous FIFO that holds received bytes until software reads them.
//   Behaviour:
//   - A pop on an empty FIFO is ignored.
//   - A push on a full FIFO is dropped, unless a pop happens in the same
//     cycle. In that case the pop frees a slot first, so the push lands.
//   Ports:
//     clk, reset_n  clock, synchronous active-low reset
//     flush         empties the FIFO (pointers and count back to zero)
//     push, data    write a byte
//     pop           discard the head entry
//     head          current head entry (not meaningful while empty)
//     full, empty   occupancy flags
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              do_push, do_pop;

  // A pop only happens when there is something to pop.
  // A push needs a free slot, or a slot freed by a pop in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Storage is not reset; the pointers alone decide what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spi_s_main.sv
// spi_s_main
//   Memory-mapped SPI subordinate (target) peripheral.
//   CS, SCK and DIN are oversampled on clk. The block shifts bytes MSB-first
//   in all four CPOL/CPHA modes. Received bytes queue in an RX FIFO; each
//   transmitted byte comes from a one-byte holding register.
//   Ports:
//     clk, reset_n   clock, synchronous active-low reset
//     addr           bus address; only ADDR+0x00..0x0c decode
//     wdata, wr      bus write data and single-cycle write strobe
//     rd             single-cycle read strobe
//     rdata, rvalid  read data, valid the cycle after rd
//     cs             chip select from the master, active low
//     sck            serial clock from the master
//     din            MOSI
//     dout           MISO, held at 1 whenever idle
module spi_s_main
  import spi_pkg::*;
#(
  parameter logic [31:0] ADDR     = 32'h0000_0000,
  parameter int          RX_DEPTH = 4,
  parameter int          SYNC     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr,
  input  logic        rd,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic        cs,
  input  logic        sck,
  input  logic        din,
  output logic        dout
);

  logic [SYNC-1:0] cs_sync, sck_sync, din_sync;
  logic            cs_d, sck_d, cs_s, sck_s, din_s;
  logic            cs_fall, cs_rise, sck_rise, sck_fall;

  spi_state_t  state;
  spi_mode_t   act_mode, ctrl_mode;
  logic        ctrl_en;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_shift, tx_hold, tx_next;
  logic [6:0]  rx_shift;
  logic [7:0]  rx_byte, rx_head;
  logic        tx_full, tx_unf, rx_ovf, rx_full, rx_empty;

  logic        sel_ctrl, sel_status, sel_tx, sel_rx;
  logic        wr_ctrl, wr_status, wr_tx, rx_pop, flush;
  logic        leading, trailing, start, sample, shift_edge, byte_done;
  logic        tx_load, tx_take, unf_evt, ovf_evt;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  // Pin synchronizers plus one more stage for edge detection. These flops
  // are deliberately not reset: they follow the pins. So if CS is held low
  // through a reset, no false CS fall appears afterwards, and the next
  // transaction starts only on a real CS fall.
  always_ff @(posedge clk) begin
    cs_sync  <= {cs_sync[SYNC-2:0], cs};
    sck_sync <= {sck_sync[SYNC-2:0], sck};
    din_sync <= {din_sync[SYNC-2:0], din};
    cs_d     <= cs_sync[SYNC-1];
    sck_d    <= sck_sync[SYNC-1];
  end

  assign cs_s     = cs_sync[SYNC-1];
  assign sck_s    = sck_sync[SYNC-1];
  assign din_s    = din_sync[SYNC-1];
  assign cs_fall  = cs_d && !cs_s;
  assign cs_rise  = !cs_d && cs_s;
  assign sck_rise = !sck_d && sck_s;
  assign sck_fall = sck_d && !sck_s;

  // Address decode and bus strobes
  assign sel_ctrl   = (addr == ADDR + CTRL_OFF);
  assign sel_status = (addr == ADDR + STATUS_OFF);
  assign sel_tx     = (addr == ADDR + TXDATA_OFF);
  assign sel_rx     = (addr == ADDR + RXDATA_OFF);
  assign wr_ctrl    = wr && sel_ctrl;
  assign wr_status  = wr && sel_status;
  assign wr_tx      = wr && sel_tx;
  assign rx_pop     = rd && sel_rx;

  // Dropping EN flushes the FIFO and aborts any transfer in the same cycle
  assign flush = wr_ctrl && ctrl_en && !wdata[CTRL_EN];

  // Leading edge = SCK moving away from its CPOL idle level.
  // Serial events are masked while CS rises or EN drops, so an abort wins
  // over a coincident sample.
  assign leading    = act_mode.cpol ? sck_fall : sck_rise;
  assign trailing   = act_mode.cpol ? sck_rise : sck_fall;
  assign start      = (state == S_IDLE) && ctrl_en && cs_fall && !flush;
  assign sample     = (state == S_ACTIVE) && !cs_rise && !flush &&
                      (act_mode.cpha ? trailing : leading);
  assign shift_edge = (state == S_ACTIVE) && !cs_rise && !flush &&
                      (act_mode.cpha ? leading : trailing);
  assign byte_done  = sample && (bit_cnt == 3'd7);
  assign rx_byte    = {rx_shift, din_s};

  // The TX shifter reloads at CS fall and at every byte boundary.
  // If the holding register is empty, it reloads with zero and flags underrun.
  assign tx_load = start || byte_done;
  assign tx_next = tx_full ? tx_hold : 8'h00;
  assign tx_take = tx_load && tx_full;
  assign unf_evt = tx_load && !tx_full;

  // A full FIFO still accepts a push when a pop happens in the same cycle
  assign ovf_evt = byte_done && rx_full && !rx_pop;

  spi_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (byte_done),
    .pop     (rx_pop),
    .data    (rx_byte),
    .head    (rx_head),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  // Transfer FSM.
  // - Mode is latched at start, so CTRL writes during a transfer take effect
  //   at the next one.
  // - CPHA=0 puts bit 7 on DOUT right at CS fall, then shifts on trailing edges.
  // - CPHA=1 waits for the first leading edge to drive bit 7.
  // - Losing CS mid-byte throws away the partial RX bits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      act_mode <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      dout     <= 1'b1;
    end else if (flush || (state == S_ACTIVE && cs_rise)) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      dout    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          dout <= 1'b1;
          if (start) begin
            state    <= S_ACTIVE;
            act_mode <= ctrl_mode;
            bit_cnt  <= '0;
            if (!ctrl_mode.cpha) begin
              dout     <= tx_next[7];
              tx_shift <= {tx_next[6:0], 1'b0};
            end else begin
              tx_shift <= tx_next;
            end
          end
        end
        S_ACTIVE: begin
          if (sample) begin
            rx_shift <= {rx_shift[5:0], din_s};
            bit_cnt  <= bit_cnt + 3'd1;
          end
          if (shift_edge) begin
            dout     <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
          if (byte_done) tx_shift <= tx_next;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register file.
  // - A new TXDATA write refills the holding register even in the cycle the
  //   old byte is taken.
  // - For the W1C flags, a new event in the same cycle as the clear keeps the
  //   flag set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= '0;
      tx_hold   <= '0;
      tx_full   <= 1'b0;
      tx_unf    <= 1'b0;
      rx_ovf    <= 1'b0;
      rdata     <= '0;
      rvalid    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en   <= wdata[CTRL_EN];
        ctrl_mode <= {wdata[CTRL_CPOL], wdata[CTRL_CPHA]};
      end
      if (wr_tx) tx_hold <= wdata[7:0];
      tx_full <= wr_tx || (tx_full && !tx_take);
      tx_unf  <= unf_evt || (tx_unf && !(wr_status && wdata[ST_TX_UNF]));
      rx_ovf  <= ovf_evt || (rx_ovf && !(wr_status && wdata[ST_RX_OVF]));
      rvalid  <= rd;
      rdata   <= rd ? rd_mux : '0;
    end
  end

  // Read mux. Reading RXDATA while the FIFO is empty returns zero.
  always_comb begin
    rd_mux = '0;
    if (sel_ctrl) begin
      rd_mux[CTRL_EN]   = ctrl_en;
      rd_mux[CTRL_CPHA] = ctrl_mode.cpha;
      rd_mux[CTRL_CPOL] = ctrl_mode.cpol;
    end else if (sel_status) begin
      rd_mux[ST_RX_VALID] = !rx_empty;
      rd_mux[ST_RX_FULL]  = rx_full;
      rd_mux[ST_BUSY]     = !cs_s;
      rd_mux[ST_TX_UNF]   = tx_unf;
      rd_mux[ST_RX_OVF]   = rx_ovf;
    end else if (sel_tx) begin
      rd_mux[7:0] = tx_hold;
    end else if (sel_rx) begin
      rd_mux[7:0] = rx_empty ? 8'h00 : rx_head;
    end
  end

  assign unused_wdata = ^wdata[31:8];

endmodule
